// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared definitions for the registered ALU pipeline stage.
//   alu_op_e    - operation codes carried on iAluOp (codes 7..15 are undefined)
//   alu_state_e - control FSM states
//   SHIFT_LEFT / SHIFT_RIGHT - direction encoding for the iterative shifter
//   is_shift_op - true for the two variable-amount shift operations
package alu_pipe_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_SHL  = 4'd4,
      ALU_SHR  = 4'd5,
      ALU_PASS = 4'd6
   } alu_op_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } alu_state_e;

   localparam logic SHIFT_LEFT  = 1'b0;
   localparam logic SHIFT_RIGHT = 1'b1;

   function automatic logic is_shift_op(input logic [3:0] op);
      return (op == ALU_SHL) || (op == ALU_SHR);
   endfunction

endpackage

// File: rtl/alu_pipe_shift_iter.sv
// alu_shift_iter: one-bit-per-cycle logical shifter.
//   clk, rst_n : clock, asynchronous active-low reset (aborts any shift)
//   start      : load data/shamt/dir (only issued while the FSM is idle)
//   dir        : SHIFT_LEFT or SHIFT_RIGHT
//   data       : value to shift
//   shamt      : number of single-bit steps to perform
//   done       : high in the cycle whose rising edge performs the final step
//   result     : work register after the step taken at the next edge
//   cout       : bit that the next step shifts out
module alu_shift_iter
   import alu_pipe_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             dir,
   input  logic [WIDTH-1:0] data,
   input  logic [SHW-1:0]   shamt,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout
);

   logic [WIDTH-1:0] work;
   logic [SHW-1:0]   count;
   logic             dir_q;

   // Work register steps once per edge until the counter drains. The
   // owner captures result/cout combinationally at the edge where done is
   // high, so the last step never needs to be stored here first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work  <= '0;
         count <= '0;
         dir_q <= SHIFT_LEFT;
      end else if (start) begin
         work  <= data;
         count <= shamt;
         dir_q <= dir;
      end else if (count != '0) begin
         work  <= result;
         count <= count - SHW'(1);
      end
   end

   // Next single-bit step and the bit it drops. Amounts beyond WIDTH
   // (non-power-of-2 widths) simply keep shifting zeros out.
   always_comb begin
      result = work;
      cout   = 1'b0;
      if (dir_q == SHIFT_RIGHT) begin
         result = {1'b0, work[WIDTH-1:1]};
         cout   = work[0];
      end else begin
         result = {work[WIDTH-2:0], 1'b0};
         cout   = work[WIDTH-1];
      end
   end

   assign done = (count == SHW'(1));

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU stage between ID and WB with per-accumulator
// carry/zero/negative flag banks and an iterative variable shifter.
//   clk, rst_n          : clock, asynchronous active-low reset
//   iValid / oReady     : request handshake, accept when both high at an edge
//   iAluOp              : operation (alu_op_e), undefined codes give R=0
//   iAccSel             : flag bank to update (out-of-range selects none)
//   iAluOper1/iAluOper2 : operands
//   iShamt              : shift amount for SHL/SHR
//   oValid              : one-cycle pulse when oAluData/flags were updated
//   oAluData            : registered result, held between completions
//   oFlagC/oFlagZ/oFlagN: flag banks, one bit per accumulator
module alu_pipe
   import alu_pipe_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int NACC  = 2,
   localparam int SHW   = $clog2(WIDTH),
   localparam int ACCW  = ($clog2(NACC) > 0) ? $clog2(NACC) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             iValid,
   output logic             oReady,
   input  logic [3:0]       iAluOp,
   input  logic [ACCW-1:0]  iAccSel,
   input  logic [WIDTH-1:0] iAluOper1,
   input  logic [WIDTH-1:0] iAluOper2,
   input  logic [SHW-1:0]   iShamt,
   output logic             oValid,
   output logic [WIDTH-1:0] oAluData,
   output logic [NACC-1:0]  oFlagC,
   output logic [NACC-1:0]  oFlagZ,
   output logic [NACC-1:0]  oFlagN
);

   alu_state_e       state, state_next;

   logic             accept;
   logic             iter_shift;
   logic             shift_start;
   logic             shift_done;
   logic             shift_cout;
   logic [WIDTH-1:0] shift_result;
   logic [ACCW-1:0]  shift_acc;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] single_res;
   logic             single_c;
   logic             single_c_we;
   logic             single_def;

   logic             comp_valid;
   logic [WIDTH-1:0] comp_res;
   logic [ACCW-1:0]  comp_sel;
   logic             comp_flag_we;
   logic             comp_c_we;
   logic             comp_c;

   assign accept      = iValid && oReady;
   assign iter_shift  = is_shift_op(iAluOp) && (iShamt != '0);
   assign shift_start = accept && iter_shift;

   alu_shift_iter #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_shift (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (shift_start),
      .dir    ((iAluOp == ALU_SHR) ? SHIFT_RIGHT : SHIFT_LEFT),
      .data   (iAluOper1),
      .shamt  (iShamt),
      .done   (shift_done),
      .result (shift_result),
      .cout   (shift_cout)
   );

   // Control state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Only a shift with a non-zero amount leaves IDLE; everything else
   // completes at its accept edge, giving one operation per cycle.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (shift_start) state_next = ST_SHIFT;
         ST_SHIFT: if (shift_done)  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Ready is purely a function of state, so it stays high through reset.
   always_comb begin
      oReady = (state == ST_IDLE);
   end

   // The flag bank of an iterative shift is remembered from accept time
   // because the request inputs are free to change while shifting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_acc <= '0;
      end else if (shift_start) begin
         shift_acc <= iAccSel;
      end
   end

   // Single-cycle datapath. Carry/borrow come from a WIDTH+1 wide add or
   // subtract; a shift by zero behaves like PASS and keeps the old carry.
   always_comb begin
      sum         = {1'b0, iAluOper1} + {1'b0, iAluOper2};
      diff        = {1'b0, iAluOper1} - {1'b0, iAluOper2};
      single_res  = '0;
      single_c    = 1'b0;
      single_c_we = 1'b0;
      single_def  = 1'b1;
      case (alu_op_e'(iAluOp))
         ALU_ADD: begin
            single_res  = sum[WIDTH-1:0];
            single_c    = sum[WIDTH];
            single_c_we = 1'b1;
         end
         ALU_SUB: begin
            single_res  = diff[WIDTH-1:0];
            single_c    = diff[WIDTH];
            single_c_we = 1'b1;
         end
         ALU_AND:  single_res = iAluOper1 & iAluOper2;
         ALU_OR:   single_res = iAluOper1 | iAluOper2;
         ALU_PASS: single_res = iAluOper1;
         ALU_SHL,
         ALU_SHR:  single_res = iAluOper1;
         default:  single_def = 1'b0;
      endcase
   end

   // Select which completion (if any) writes the output registers this
   // edge. The two sources are exclusive since accept needs IDLE.
   always_comb begin
      comp_valid   = 1'b0;
      comp_res     = single_res;
      comp_sel     = iAccSel;
      comp_flag_we = single_def;
      comp_c_we    = single_c_we;
      comp_c       = single_c;
      if ((state == ST_SHIFT) && shift_done) begin
         comp_valid   = 1'b1;
         comp_res     = shift_result;
         comp_sel     = shift_acc;
         comp_flag_we = 1'b1;
         comp_c_we    = 1'b1;
         comp_c       = shift_cout;
      end else if (accept && !iter_shift) begin
         comp_valid = 1'b1;
      end
   end

   // Result and flag banks only move on a completion edge. Z/N come from
   // the new result; a select with no matching bank updates no flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oValid   <= 1'b0;
         oAluData <= '0;
         oFlagC   <= '0;
         oFlagZ   <= '0;
         oFlagN   <= '0;
      end else begin
         oValid <= comp_valid;
         if (comp_valid) begin
            oAluData <= comp_res;
            for (int i = 0; i < NACC; i++) begin
               if (comp_flag_we && (comp_sel == ACCW'(i))) begin
                  oFlagZ[i] <= (comp_res == '0);
                  oFlagN[i] <= comp_res[WIDTH-1];
                  if (comp_c_we) begin
                     oFlagC[i] <= comp_c;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed, table-driven bench for alu_pipe. One instance uses
// the default NACC=2, a second uses NACC=3 for the extra bank and the
// out-of-range select case.
module tb_alu_pipe;
   import alu_pipe_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       v2 = 1'b0;
   logic [3:0] op2 = '0;
   logic [0:0] sel2 = '0;
   logic [7:0] a2 = '0, b2 = '0;
   logic [2:0] sh2 = '0;
   logic       ready2, valid2;
   logic [7:0] data2;
   logic [1:0] c2, z2, n2;

   logic       v3 = 1'b0;
   logic [3:0] op3 = '0;
   logic [1:0] sel3 = '0;
   logic [7:0] a3 = '0, b3 = '0;
   logic [2:0] sh3 = '0;
   logic       ready3, valid3;
   logic [7:0] data3;
   logic [2:0] c3, z3, n3;

   int checks = 0;
   int fails  = 0;
   int cycles, lowCnt;

   typedef struct {
      logic [3:0] op;
      logic [1:0] sel;
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] sh;
      logic [7:0] expData;
      logic [2:0] expC;
      logic [2:0] expZ;
      logic [2:0] expN;
   } vec_t;

   vec_t vecs2[10];
   vec_t vecs3[5];

   alu_pipe #(.WIDTH(8), .NACC(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .iValid(v2), .oReady(ready2),
      .iAluOp(op2), .iAccSel(sel2), .iAluOper1(a2), .iAluOper2(b2),
      .iShamt(sh2), .oValid(valid2), .oAluData(data2),
      .oFlagC(c2), .oFlagZ(z2), .oFlagN(n2)
   );

   alu_pipe #(.WIDTH(8), .NACC(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .iValid(v3), .oReady(ready3),
      .iAluOp(op3), .iAccSel(sel3), .iAluOper1(a3), .iAluOper2(b3),
      .iShamt(sh3), .oValid(valid3), .oAluData(data3),
      .oFlagC(c3), .oFlagZ(z3), .oFlagN(n3)
   );

   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: time limit reached, required end of test");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int dutSel, input logic [3:0] op,
                                input logic [1:0] sel, input logic [7:0] a,
                                input logic [7:0] b, input logic [2:0] sh);
      if (dutSel == 0) begin
         v2 = 1'b1; op2 = op; sel2 = sel[0]; a2 = a; b2 = b; sh2 = sh;
      end else begin
         v3 = 1'b1; op3 = op; sel3 = sel; a3 = a; b3 = b; sh3 = sh;
      end
   endtask

   task automatic checkVector(input int dutSel, input string tag, input vec_t v);
      if (dutSel == 0) begin
         checkOutput({tag, " valid"}, 32'(valid2), 32'd1);
         checkOutput({tag, " ready"}, 32'(ready2), 32'd1);
         checkOutput({tag, " data"},  32'(data2),  32'(v.expData));
         checkOutput({tag, " flagC"}, 32'(c2),     32'(v.expC[1:0]));
         checkOutput({tag, " flagZ"}, 32'(z2),     32'(v.expZ[1:0]));
         checkOutput({tag, " flagN"}, 32'(n2),     32'(v.expN[1:0]));
      end else begin
         checkOutput({tag, " valid"}, 32'(valid3), 32'd1);
         checkOutput({tag, " ready"}, 32'(ready3), 32'd1);
         checkOutput({tag, " data"},  32'(data3),  32'(v.expData));
         checkOutput({tag, " flagC"}, 32'(c3),     32'(v.expC));
         checkOutput({tag, " flagZ"}, 32'(z3),     32'(v.expZ));
         checkOutput({tag, " flagN"}, 32'(n3),     32'(v.expN));
      end
   endtask

   // Called just after an accept edge; returns edges until oValid and the
   // number of sampled cycles with oReady low.
   task automatic waitValid2(input int limit, output int nCycles, output int nLow);
      nCycles = 0;
      nLow    = 0;
      for (int k = 0; k < limit; k++) begin
         @(negedge clk);
         if (valid2) return;
         if (!ready2) nLow++;
         @(posedge clk);
         nCycles++;
      end
      checks++;
      fails++;
      $display("[TB] FAIL wait for valid: no completion within %0d cycles", limit);
   endtask

   task automatic checkFlags2(input string tag, input logic [1:0] c,
                              input logic [1:0] z, input logic [1:0] n);
      checkOutput({tag, " flagC"}, 32'(c2), 32'(c));
      checkOutput({tag, " flagZ"}, 32'(z2), 32'(z));
      checkOutput({tag, " flagN"}, 32'(n2), 32'(n));
   endtask

   initial begin
      //                op     sel    a      b      sh    data   C       Z       N
      vecs2[0] = '{4'd0, 2'd0, 8'hF0, 8'h20, 3'd0, 8'h10, 3'b001, 3'b000, 3'b000};
      vecs2[1] = '{4'd1, 2'd1, 8'h05, 8'h05, 3'd0, 8'h00, 3'b001, 3'b010, 3'b000};
      vecs2[2] = '{4'd1, 2'd1, 8'h03, 8'h04, 3'd0, 8'hFF, 3'b011, 3'b000, 3'b010};
      vecs2[3] = '{4'd2, 2'd0, 8'h0F, 8'h3C, 3'd0, 8'h0C, 3'b011, 3'b000, 3'b010};
      vecs2[4] = '{4'd3, 2'd0, 8'h80, 8'h01, 3'd0, 8'h81, 3'b011, 3'b000, 3'b011};
      vecs2[5] = '{4'd6, 2'd1, 8'h00, 8'h5A, 3'd0, 8'h00, 3'b011, 3'b010, 3'b001};
      vecs2[6] = '{4'd4, 2'd0, 8'h55, 8'h00, 3'd0, 8'h55, 3'b011, 3'b010, 3'b000};
      vecs2[7] = '{4'd0, 2'd1, 8'h7F, 8'h01, 3'd0, 8'h80, 3'b001, 3'b000, 3'b010};
      vecs2[8] = '{4'hF, 2'd1, 8'h12, 8'h34, 3'd0, 8'h00, 3'b001, 3'b000, 3'b010};
      vecs2[9] = '{4'd5, 2'd0, 8'h00, 8'h00, 3'd0, 8'h00, 3'b001, 3'b001, 3'b010};

      vecs3[0] = '{4'd0, 2'd0, 8'hFF, 8'h01, 3'd0, 8'h00, 3'b001, 3'b001, 3'b000};
      vecs3[1] = '{4'd0, 2'd1, 8'h40, 8'h40, 3'd0, 8'h80, 3'b001, 3'b001, 3'b010};
      vecs3[2] = '{4'hF, 2'd1, 8'h12, 8'h34, 3'd0, 8'h00, 3'b001, 3'b001, 3'b010};
      vecs3[3] = '{4'd0, 2'd3, 8'h01, 8'h01, 3'd0, 8'h02, 3'b001, 3'b001, 3'b010};
      vecs3[4] = '{4'd2, 2'd2, 8'h0F, 8'hF0, 3'd0, 8'h00, 3'b001, 3'b101, 3'b010};

      // Reset state, sampled while reset is still asserted.
      #12;
      checkOutput("reset ready", 32'(ready2), 32'd1);
      checkOutput("reset valid", 32'(valid2), 32'd0);
      checkOutput("reset data",  32'(data2),  32'd0);
      checkFlags2("reset", 2'b00, 2'b00, 2'b00);
      checkOutput("reset ready3", 32'(ready3), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("idle valid", 32'(valid2), 32'd0);

      // Back-to-back single-cycle operations, one per clock.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, vecs2[i].op, vecs2[i].sel, vecs2[i].a, vecs2[i].b, vecs2[i].sh);
         @(posedge clk);
         @(negedge clk);
         checkVector(0, $sformatf("vec2[%0d]", i), vecs2[i]);
      end
      v2 = 1'b0;

      // SHL 0x81 by 3 on acc0.
      applyStimulus(0, 4'd4, 2'd0, 8'h81, 8'h00, 3'd3);
      @(posedge clk);
      #1 v2 = 1'b0;
      waitValid2(20, cycles, lowCnt);
      checkOutput("shl3 latency", 32'(cycles), 32'd3);
      checkOutput("shl3 ready low", 32'(lowCnt), 32'd3);
      checkOutput("shl3 data", 32'(data2), 32'h08);
      checkOutput("shl3 ready", 32'(ready2), 32'd1);
      checkFlags2("shl3", 2'b00, 2'b00, 2'b10);

      // SHR 0x81 by 1 on acc0.
      applyStimulus(0, 4'd5, 2'd0, 8'h81, 8'h00, 3'd1);
      @(posedge clk);
      #1 v2 = 1'b0;
      waitValid2(20, cycles, lowCnt);
      checkOutput("shr1 latency", 32'(cycles), 32'd1);
      checkOutput("shr1 data", 32'(data2), 32'h40);
      checkFlags2("shr1", 2'b01, 2'b00, 2'b10);

      // SHL 0x01 by 7 with an AND request held throughout the shift.
      applyStimulus(0, 4'd4, 2'd0, 8'h01, 8'h00, 3'd7);
      @(posedge clk);
      #1 applyStimulus(0, 4'd2, 2'd0, 8'hF0, 8'h3C, 3'd0);
      waitValid2(30, cycles, lowCnt);
      checkOutput("shl7 latency", 32'(cycles), 32'd7);
      checkOutput("shl7 ready low", 32'(lowCnt), 32'd7);
      checkOutput("shl7 data", 32'(data2), 32'h80);
      checkFlags2("shl7", 2'b00, 2'b00, 2'b11);
      @(posedge clk);
      #1 v2 = 1'b0;
      @(negedge clk);
      checkOutput("held and valid", 32'(valid2), 32'd1);
      checkOutput("held and data", 32'(data2), 32'h30);
      checkFlags2("held and", 2'b00, 2'b00, 2'b10);
      @(negedge clk);
      checkOutput("held and single pulse", 32'(valid2), 32'd0);
      checkOutput("held and data hold", 32'(data2), 32'h30);

      // Reset during cycle 2 of a shift by 5.
      applyStimulus(0, 4'd5, 2'd1, 8'hFF, 8'h00, 3'd5);
      @(posedge clk);
      #1 v2 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("abort ready", 32'(ready2), 32'd1);
      checkOutput("abort valid", 32'(valid2), 32'd0);
      checkOutput("abort data",  32'(data2),  32'd0);
      checkFlags2("abort", 2'b00, 2'b00, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checkOutput($sformatf("abort no valid %0d", i), 32'(valid2), 32'd0);
      end
      checkOutput("abort idle ready", 32'(ready2), 32'd1);

      // NACC=3: undefined op, out-of-range select, third bank.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, vecs3[i].op, vecs3[i].sel, vecs3[i].a, vecs3[i].b, vecs3[i].sh);
         @(posedge clk);
         @(negedge clk);
         checkVector(1, $sformatf("vec3[%0d]", i), vecs3[i]);
      end
      v3 = 1'b0;
      @(negedge clk);
      checkOutput("vec3 idle valid", 32'(valid3), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
